// File: rtl/prog_ctr_if.sv
// rtl/prog_ctr_if.sv - decoder/ALU-side bundle for the program-counter stage.
interface prog_ctr_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             start;
    logic [PC_W-1:0]  start_addr;
    logic             halt;
    logic             flag_we;
    logic             zero;
    logic             parity;
    logic             branch_en;
    logic             branch_cond;
    logic             abs_jump;
    logic [PC_W-1:0]  target;
    logic [7:0]       offset;
    logic [PC_W-1:0]  pc;
    logic             running;
    logic             done;
    logic             zero_flag;
    logic             parity_flag;
    logic [CNT_W-1:0] inst_count;

    modport master (
        output start, start_addr, halt, flag_we, zero, parity,
               branch_en, branch_cond, abs_jump, target, offset,
        input  pc, running, done, zero_flag, parity_flag, inst_count
    );

    modport slave (
        input  start, start_addr, halt, flag_we, zero, parity,
               branch_en, branch_cond, abs_jump, target, offset,
        output pc, running, done, zero_flag, parity_flag, inst_count
    );
endinterface

// File: rtl/prog_ctr.sv
// rtl/prog_ctr.sv - PC sequencer with flag registers, bypassed branch resolution and retire counter.
module prog_ctr #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    prog_ctr_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_zf;
    logic             r_pf;
    logic             r_running;
    logic             r_done;

    logic             w_z;
    logic             w_p;
    logic             w_taken;
    logic [PC_W-1:0]  w_off_ext;
    logic [PC_W-1:0]  w_next_pc;

    // Flags written this cycle are used directly so a compare and its branch can share one instruction.
    assign w_z       = bus.flag_we ? bus.zero   : r_zf;
    assign w_p       = bus.flag_we ? bus.parity : r_pf;
    assign w_taken   = bus.branch_en & (bus.branch_cond ? w_p : ~w_z);
    assign w_off_ext = PC_W'($signed(bus.offset));

    always_comb begin
        w_next_pc = r_pc + PC_W'(1);
        if (w_taken) begin
            if (bus.abs_jump) begin
                w_next_pc = bus.target;
            end else begin
                w_next_pc = r_pc + w_off_ext;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_zf      <= 1'b0;
            r_pf      <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_cnt != {CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (bus.flag_we) begin
                        r_zf <= bus.zero;
                        r_pf <= bus.parity;
                    end
                    if (bus.halt) begin
                        r_state   <= S_DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_pc <= w_next_pc;
                    end
                end
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state   <= S_RUN;
                        r_pc      <= bus.start_addr;
                        r_cnt     <= '0;
                        r_zf      <= 1'b0;
                        r_pf      <= 1'b0;
                        r_running <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.running     = r_running;
    assign bus.done        = r_done;
    assign bus.zero_flag   = r_zf;
    assign bus.parity_flag = r_pf;
    assign bus.inst_count  = r_cnt;
endmodule

// File: doc/prog_ctr.md
# prog_ctr

Program-counter and branch-resolution stage that sits directly downstream of the 8-bit ALU. It registers the ALU's Zero/Parity flags and resolves BNE/parity branches from them, using a same-cycle bypass. It sequences PC through Idle/Run/Done and counts retired instructions. PC feeds instruction memory; the decoder supplies Halt, branch, and flag-write controls.

## Interface
- PC_W, 10, program-counter width (instruction memory depth = 2^PC_W)
- CNT_W, 16, retired-instruction counter width
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  begin execution at StartAddr (sampled only in Idle/Done)
- StartAddr  in  PC_W  first instruction address
- Halt  in  1  current instruction is the halt instruction
- FlagWe  in  1  capture the ALU Zero/Parity into the flag registers this cycle
- Zero  in  1  ALU Zero flag (combinational, current instruction)
- Parity  in  1  ALU Parity flag (combinational, current instruction)
- BranchEn  in  1  current instruction is a conditional branch
- BranchCond  in  1  0: take if Z==0 (not-equal); 1: take if P==1
- AbsJump  in  1  1: target = Target; 0: target = PC + sext(Offset)
- Target  in  PC_W  absolute branch target (from the branch LUT)
- Offset  in  8  signed relative branch offset, two's complement
- PC  out  PC_W  current instruction address
- Running  out  1  high in Run
- Done  out  1  high in Done
- ZeroFlag  out  1  registered Zero
- ParityFlag  out  1  registered Parity
- InstCount  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE/DONE with Start=1: state←RUN; PC←StartAddr; InstCount←0; ZeroFlag←0; ParityFlag←0.
- IDLE/DONE with Start=0: all registers hold.
- RUN: Start is ignored. Halt, BranchEn, and FlagWe take effect only in RUN; they are ignored in IDLE/DONE.
- RUN, every cycle: InstCount increments by 1 and saturates at all-ones. The halt cycle counts.
- RUN with Halt=1: state←DONE and PC holds. Halt overrides BranchEn. FlagWe is still honoured.
- Effective flags for the branch decision:
  - Z = FlagWe ? Zero : ZeroFlag
  - P = FlagWe ? Parity : ParityFlag
  - This bypass gives the ALU's BNE subtract and the branch effect in the same instruction.
- Taken = BranchEn & (BranchCond ? P : ~Z).
- Next PC (RUN, no Halt):
  - Taken & AbsJump → Target
  - Taken & ~AbsJump → PC + sext(Offset)
  - otherwise → PC + 1
- PC arithmetic is modulo 2^PC_W. Offset is sign-extended from 8 bits to PC_W. For PC_W<8, Offset is truncated to PC_W.
- Flags: with FlagWe=1 in RUN, ZeroFlag←Zero and ParityFlag←Parity; otherwise they hold.
- Reset (asynchronous, any time, including mid-RUN):
  - state=IDLE, PC=0, InstCount=0, ZeroFlag=0, ParityFlag=0.
  - Running=0, Done=0.

## Timing
- All state changes occur on the rising edge of Clk. Outputs are register-driven, with no combinational input-to-output paths.
- Branch latency is one cycle: the decision in cycle n sets PC in cycle n+1. There are no delay slots and no bubbles.
- Start→RUN latency is one cycle: Running=1 and PC=StartAddr on the edge that samples Start.
- Halt→Done latency is one cycle. Done stays high until Start or Reset.
- Start and Halt in the same RUN cycle: Halt is taken and Start is ignored.
- Start held high across RUN→DONE: execution restarts on the first DONE cycle edge. This is legal and intended.
- Reset dominates every input.

## Test plan
- **Reset mid-run:** Start with StartAddr=0x010, run 3 cycles, assert Reset asynchronously mid-cycle → PC=0, Running=0, InstCount=0 immediately, without waiting for a clock edge.
- **Sequential run and halt:** Start with StartAddr=0x3FE, 4 RUN cycles with no branches → PC sequence 0x3FE, 0x3FF, 0x000, 0x001 (wrap). Then Halt → Done=1, PC holds 0x002, InstCount=5.
- **BNE with bypass:** PC=0x020, FlagWe=1, Zero=0, BranchEn=1, BranchCond=0, AbsJump=0, Offset=0xFC → next PC=0x01C. Repeat with Zero=1 → next PC=0x021, ZeroFlag=1.
- **Latched parity, absolute jump:**
  - Cycle a: FlagWe=1, Parity=1, BranchEn=0.
  - Cycle b: FlagWe=0, BranchEn=1, BranchCond=1, AbsJump=1, Target=0x155 → next PC=0x155.
  - Cycle c: FlagWe=1, Parity=0, same branch → not taken (bypass overrides ParityFlag=1).
- **Halt vs branch; Start ignored in RUN:** Halt=1 and taken branch in the same cycle → PC holds, Done=1. Start pulsed while Running=1 → PC continues PC+1, InstCount not cleared.
- **Counter saturation:** force a long run with CNT_W=4 → InstCount stops at 0xF and Running stays 1.
